// File: rtl/oled_print_arbiter_pkg.sv
// oled_print_arbiter_pkg: shared state encoding, sizing defaults and byte-select helper
// for the OLED print arbiter and its round-robin selector.
package oled_print_arbiter_pkg;

  localparam int          NREQ_DEFAULT    = 3;
  localparam logic [23:0] TIMEOUT_DEFAULT = 24'd4_000_000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    SEND_HDR,
    SEND_DATA,
    WAIT_DONE,
    ACK
  } state_t;

  // Byte i of a 32-bit value, byte 0 being the least significant.
  function automatic logic [7:0] val_byte(input logic [31:0] v, input logic [1:0] i);
    return v[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/oled_rr_arb.sv
// oled_rr_arb: three-way round-robin selector; the search starts at the requester after last.
// Ports:
//   req  - pending requests, one bit per requester
//   last - index of the most recent grant
//   gnt  - one-hot grant (all zero when no request)
//   idx  - index of the granted requester (don't-care when req is zero)
module oled_rr_arb (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt,
  output logic [1:0] idx
);

  logic [1:0] c0, c1, c2;

  always_comb begin
    c0  = (last == 2'd0) ? 2'd1 : (last == 2'd1) ? 2'd2 : 2'd0;
    c1  = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
    c2  = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    idx = req[c0] ? c0 : req[c1] ? c1 : c2;
    gnt = (req == 3'b000) ? 3'b000 : 3'b001 << idx;
  end

endmodule

// File: rtl/oled_print_arbiter.sv
// oled_print_arbiter: grants one of three print requesters round-robin and streams its
// header byte plus 1..4 value bytes (MSB first) to the OLED display engine.
// Ports:
//   clk, rst_n            - clock and synchronous active-low reset
//   req/req_pos/req_val/req_len - per-requester request level, header, value, byte count-1
//   ack, err              - one-cycle completion pulse to the granted requester; err marks a timeout
//   busy, gnt_id          - job in flight; current or last granted requester
//   disp_rdy, disp_done   - display engine ready / print-complete pulse
//   disp_wen, disp_din    - contiguous byte burst to the display engine
module oled_print_arbiter
  import oled_print_arbiter_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int          NREQ           = NREQ_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_pos,
  input  logic [32*NREQ-1:0]  req_val,
  input  logic [2*NREQ-1:0]   req_len,
  output logic [NREQ-1:0]     ack,
  output logic                err,
  output logic                busy,
  output logic [1:0]          gnt_id,
  input  logic                disp_rdy,
  output logic                disp_wen,
  output logic [7:0]          disp_din,
  input  logic                disp_done
);

  state_t      state, state_n;
  logic [2:0]  arb_gnt;
  logic [1:0]  arb_idx;
  logic [7:0]  sel_pos;
  logic [31:0] sel_val;
  logic [1:0]  sel_len;
  logic [2:0]  gnt_oh, gnt_oh_n;
  logic [1:0]  gnt_id_n;
  logic [7:0]  pos_q, pos_n;
  logic [31:0] val_q, val_n;
  logic [1:0]  len_q, len_n;
  logic [1:0]  cnt, cnt_n;
  logic [23:0] tmo, tmo_n;
  logic        tmo_hit;
  logic [2:0]  ack_n;
  logic        err_n, busy_n, wen_n;
  logic [7:0]  din_n;

  oled_rr_arb u_arb (
    .req  (req),
    .last (gnt_id),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  always_comb begin
    sel_pos = req_pos[{arb_idx, 3'b000} +: 8];
    sel_val = req_val[{arb_idx, 5'b00000} +: 32];
    sel_len = req_len[{arb_idx, 1'b0} +: 2];
    tmo_hit = tmo == TIMEOUT_CYCLES - 24'd1;
  end

  always_comb begin
    state_n  = state;
    gnt_oh_n = gnt_oh;
    gnt_id_n = gnt_id;
    pos_n    = pos_q;
    val_n    = val_q;
    len_n    = len_q;
    cnt_n    = cnt;
    tmo_n    = tmo;
    ack_n    = 3'b000;
    err_n    = 1'b0;
    busy_n   = busy;
    wen_n    = disp_wen;
    din_n    = disp_din;
    case (state)
      IDLE: if (req != 3'b000) begin
        state_n  = WAIT_RDY;
        gnt_oh_n = arb_gnt;
        gnt_id_n = arb_idx;
        pos_n    = sel_pos;
        val_n    = sel_val;
        len_n    = sel_len;
        busy_n   = 1'b1;
        tmo_n    = 24'd0;
      end
      WAIT_RDY: if (disp_rdy) begin
        state_n = SEND_HDR;
        wen_n   = 1'b1;
        din_n   = pos_q;
      end else if (tmo_hit) begin
        state_n = ACK;
        ack_n   = gnt_oh;
        err_n   = 1'b1;
      end else begin
        tmo_n = tmo + 24'd1;
      end
      SEND_HDR: begin
        state_n = SEND_DATA;
        cnt_n   = len_q;
        din_n   = val_byte(val_q, len_q);
      end
      // cnt holds the index of the byte currently on disp_din.
      SEND_DATA: if (cnt == 2'd0) begin
        state_n = WAIT_DONE;
        wen_n   = 1'b0;
        tmo_n   = 24'd0;
      end else begin
        cnt_n = cnt - 2'd1;
        din_n = val_byte(val_q, cnt - 2'd1);
      end
      // disp_done is tested first so it wins over a same-cycle timeout.
      WAIT_DONE: if (disp_done) begin
        state_n = ACK;
        ack_n   = gnt_oh;
      end else if (tmo_hit) begin
        state_n = ACK;
        ack_n   = gnt_oh;
        err_n   = 1'b1;
      end else begin
        tmo_n = tmo + 24'd1;
      end
      ACK: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_oh   <= 3'b100;
      gnt_id   <= 2'd2;
      pos_q    <= 8'd0;
      val_q    <= 32'd0;
      len_q    <= 2'd0;
      cnt      <= 2'd0;
      tmo      <= 24'd0;
      ack      <= 3'b000;
      err      <= 1'b0;
      busy     <= 1'b0;
      disp_wen <= 1'b0;
      disp_din <= 8'd0;
    end else begin
      state    <= state_n;
      gnt_oh   <= gnt_oh_n;
      gnt_id   <= gnt_id_n;
      pos_q    <= pos_n;
      val_q    <= val_n;
      len_q    <= len_n;
      cnt      <= cnt_n;
      tmo      <= tmo_n;
      ack      <= ack_n;
      err      <= err_n;
      busy     <= busy_n;
      disp_wen <= wen_n;
      disp_din <= din_n;
    end
  end

endmodule

// File: tb/tb_oled_print_arbiter.sv
// tb_oled_print_arbiter: table-driven, hand-sequenced and randomized checks of the print arbiter.
module tb_oled_print_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] req_pos;
  logic [95:0] req_val;
  logic [5:0]  req_len;
  logic [2:0]  ack;
  logic        err, busy, disp_rdy, disp_wen, disp_done;
  logic [1:0]  gnt_id;
  logic [7:0]  disp_din;

  int checks = 0;
  int errors = 0;
  int job_no = 0;
  int last_id = 2;

  always #5 clk = ~clk;

  oled_print_arbiter #(.TIMEOUT_CYCLES(24'd16), .NREQ(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_pos   (req_pos),
    .req_val   (req_val),
    .req_len   (req_len),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .gnt_id    (gnt_id),
    .disp_rdy  (disp_rdy),
    .disp_wen  (disp_wen),
    .disp_din  (disp_din),
    .disp_done (disp_done)
  );

  typedef struct {
    logic [2:0]  r;
    logic [7:0]  pos;
    logic [31:0] val;
    logic [1:0]  len;
    int          rdy_delay;
    int          done_delay;
    int          exp_id;
    bit          exp_err;
    logic [7:0]  exp_b1;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (job %0d): got %0h expected %0h", name, job_no, act, exp);
    end
  endtask

  // Round-robin rule: first pending requester after the last grant, wrapping.
  function automatic int rr_pick(input int last, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int j = (last + k) % 3;
      if (r[j[1:0]]) return j;
    end
    return 0;
  endfunction

  task automatic set_all(input logic [2:0] r, input logic [7:0] pos, input logic [31:0] val,
                         input logic [1:0] len);
    req     = r;
    req_pos = {3{pos}};
    req_val = {3{val}};
    req_len = {3{len}};
  endtask

  // Runs one job from an IDLE negedge to the IDLE negedge after ack.
  // done_delay < 0 means disp_done never arrives.
  task automatic do_job(input logic [2:0] r, input int rdy_delay, input int done_delay,
                        input bit drop, input int exp_id, input bit exp_err,
                        output logic [7:0] b1);
    int id, n;
    logic [7:0]  pos;
    logic [31:0] val;
    logic [1:0]  len;
    logic [7:0]  exp_q[$];
    logic [7:0]  got[$];
    job_no++;
    req      = r;
    disp_rdy = (rdy_delay == 0);
    id  = rr_pick(last_id, r);
    pos = 8'(req_pos >> (8 * id));
    val = 32'(req_val >> (32 * id));
    len = 2'(req_len >> (2 * id));
    exp_q = {pos};
    for (int i = int'(len); i >= 0; i--) exp_q.push_back(8'(val >> (8 * i)));
    n = 0;
    @(negedge clk);
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("grant_busy", busy, 1'b1);
    chk("gnt_id", gnt_id, (exp_id >= 0) ? exp_id : id);
    req_pos = $urandom;
    req_val = {$urandom, $urandom, $urandom};
    req_len = 6'($urandom);
    for (int i = 0; i < rdy_delay; i++) begin
      chk("wen_while_not_rdy", disp_wen, 1'b0);
      disp_done = (i == 0);
      @(negedge clk);
    end
    disp_done = 1'b0;
    disp_rdy  = 1'b1;
    @(negedge clk);
    chk("burst_start", disp_wen, 1'b1);
    n = 0;
    while (disp_wen && n < 8) begin
      got.push_back(disp_din);
      @(negedge clk);
      n++;
    end
    disp_rdy = 1'b0;
    chk("burst_len", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("burst_byte", got[i], exp_q[i]);
    b1 = (got.size() > 1) ? got[1] : 8'h00;
    chk("din_hold", disp_din, exp_q[exp_q.size() - 1]);
    if (done_delay >= 0) begin
      for (int i = 0; i < done_delay; i++) begin
        chk("ack_early", ack, 3'b000);
        @(negedge clk);
      end
      disp_done = 1'b1;
      @(negedge clk);
      disp_done = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        chk("ack_before_timeout", ack, 3'b000);
        @(negedge clk);
      end
    end
    chk("ack", ack, 3'b001 << id);
    chk("err", err, exp_err);
    chk("busy_at_ack", busy, 1'b1);
    if (drop) req = 3'b000;
    @(negedge clk);
    chk("ack_single", ack, 3'b000);
    chk("err_single", err, 1'b0);
    chk("busy_after", busy, 1'b0);
    last_id = id;
  endtask

  initial begin
    logic [7:0] b1;
    int n;
    tbl[0] = '{3'b001, 8'h23, 32'h0000_00AB, 2'd0, 0, 2, 0, 1'b0, 8'hAB};
    tbl[1] = '{3'b001, 8'h45, 32'hDEAD_BEEF, 2'd3, 0, 1, 0, 1'b0, 8'hDE};
    tbl[2] = '{3'b010, 8'h5A, 32'h0000_1234, 2'd1, 10, 3, 1, 1'b0, 8'h12};
    tbl[3] = '{3'b100, 8'h77, 32'h00C0_FFEE, 2'd2, 0, -1, 2, 1'b1, 8'hC0};
    tbl[4] = '{3'b011, 8'h10, 32'h0000_0099, 2'd0, 2, 15, 0, 1'b0, 8'h99};
    tbl[5] = '{3'b011, 8'h11, 32'h0000_0055, 2'd0, 0, 0, 1, 1'b0, 8'h55};

    rst_n = 1'b0;
    set_all(3'b111, 8'hFF, 32'hFFFF_FFFF, 2'd3);
    disp_rdy  = 1'b1;
    disp_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 3'b000);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wen", disp_wen, 1'b0);
    chk("rst_din", disp_din, 8'h00);
    chk("rst_gnt_id", gnt_id, 2'd2);
    req = 3'b000;
    disp_rdy = 1'b0;
    disp_done = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      set_all(tbl[i].r, tbl[i].pos, tbl[i].val, tbl[i].len);
      do_job(tbl[i].r, tbl[i].rdy_delay, tbl[i].done_delay, 1'b1, tbl[i].exp_id, tbl[i].exp_err, b1);
      chk("first_data_byte", b1, tbl[i].exp_b1);
    end

    // Reset in the middle of the data phase.
    job_no++;
    set_all(3'b010, 8'h66, 32'h0102_0304, 2'd3);
    disp_rdy = 1'b1;
    n = 0;
    while (!disp_wen && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_gnt_id", gnt_id, rr_pick(last_id, 3'b010));
    repeat (2) @(negedge clk);
    chk("mid_data_byte", disp_din, 8'h02);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_wen", disp_wen, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ack", ack, 3'b000);
    chk("mid_rst_gnt_id", gnt_id, 2'd2);
    rst_n = 1'b1;
    req = 3'b000;
    disp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_ack", ack, 3'b000);
    end
    last_id = 2;

    // All requesters held continuously: rotation 0,1,2,0 after reset.
    set_all(3'b111, 8'h31, 32'h0000_4242, 2'd1);
    for (int k = 0; k < 4; k++) do_job(3'b111, 0, 1, 1'b0, k % 3, 1'b0, b1);
    req = 3'b000;
    @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      int rd, dd;
      logic [2:0] r;
      r       = 3'($urandom_range(1, 7));
      req_pos = 24'($urandom);
      req_val = {$urandom, $urandom, $urandom};
      req_len = 6'($urandom);
      rd      = $urandom_range(0, 4);
      dd      = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
      do_job(r, rd, dd, 1'($urandom_range(0, 1)), -1, dd < 0, b1);
    end
    req = 3'b000;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
